// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = host/byte source side, slave = loader side.
interface imem_loader_if #(parameter int ADDR_WIDTH = 12);
  logic                  start;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  cpu_rst;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory
// while holding the core in reset; releases the core once the image is written.
module imem_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);
  localparam int          IDX_W     = ADDR_WIDTH - 2;
  localparam logic [16:0] MEM_WORDS = 17'(1) << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t            r_state, w_next;
  logic [15:0]       r_len;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        r_bcnt;
  logic [31:0]       r_word;
  logic              r_cpu_rst;

  logic              w_ready, w_accept, w_start_ok, w_last;
  logic [15:0]       w_n;

  assign w_accept = bus.byte_valid & w_ready;
  assign w_n      = {bus.byte_data, r_len[7:0]};
  assign w_last   = (16'(r_idx) == (r_len - 16'd1));

  always_comb begin
    w_next     = r_state;
    w_ready    = 1'b0;
    w_start_ok = 1'b0;
    bus.wr_en  = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start_ok = bus.start;
        if (bus.start) w_next = S_LEN0;
      end
      S_LEN0: begin
        w_ready  = 1'b1;
        bus.busy = 1'b1;
        if (w_accept) w_next = S_LEN1;
      end
      S_LEN1: begin
        w_ready  = 1'b1;
        bus.busy = 1'b1;
        if (w_accept) begin
          if (w_n == 16'd0)                 w_next = S_DONE;
          else if ({1'b0, w_n} > MEM_WORDS) w_next = S_ERR;
          else                              w_next = S_DATA;
        end
      end
      S_DATA: begin
        w_ready  = 1'b1;
        bus.busy = 1'b1;
        if (w_accept && r_bcnt == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        bus.wr_en = 1'b1;
        bus.busy  = 1'b1;
        w_next    = w_last ? S_DONE : S_DATA;
      end
      S_DONE: begin
        bus.done   = 1'b1;
        w_start_ok = bus.start;
        w_next     = bus.start ? S_LEN0 : S_IDLE;
      end
      S_ERR: begin
        bus.err    = 1'b1;
        w_start_ok = bus.start;
        if (bus.start) w_next = S_LEN0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      r_bcnt    <= '0;
      r_word    <= '0;
      r_cpu_rst <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_idx     <= '0;
        r_bcnt    <= '0;
        r_cpu_rst <= 1'b1;
      end
      if (r_state == S_LEN0 && w_accept) r_len[7:0]  <= bus.byte_data;
      if (r_state == S_LEN1 && w_accept) r_len[15:8] <= bus.byte_data;
      // Shift right so the first byte of a word ends up in bits [7:0].
      if (r_state == S_DATA && w_accept) begin
        r_word <= {bus.byte_data, r_word[31:8]};
        r_bcnt <= r_bcnt + 2'd1;
      end
      if (r_state == S_WRITE && !w_last) r_idx <= r_idx + 1'b1;
      // Core leaves reset on the same cycle done is shown.
      if (w_next == S_DONE && r_state != S_DONE) r_cpu_rst <= 1'b0;
      if (w_next == S_ERR)                       r_cpu_rst <= 1'b1;
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.wr_addr    = {r_idx, 2'b00};
  assign bus.wr_data    = r_word;
  assign bus.cpu_rst    = r_cpu_rst;
endmodule
